// File: rtl/prediction_reader.sv
// prediction_reader: IF-stage read side of the branch-prediction tables.
// Resolves write-port-2 collisions on stat/trend counts, picks the predictor
// with the best signed stat count (trend breaks ties, then GHP > LHP > SP),
// and carries the prediction metadata down the IF->ID->EX pipeline registers.
module prediction_reader #(
    parameter int unsigned JUMP_STATUS_COUNTER_WIDTH = 2,
    parameter int unsigned STAT_COUNTER_WIDTH        = 5
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 PL_stall,
    input  logic                                 flush_id,
    input  logic                                 flush_ex,
    input  logic                                 branch_valid,
    input  logic [2:0]                           addr,
    input  logic                                 RD_SP_index,
    input  logic [JUMP_STATUS_COUNTER_WIDTH-1:0] RD_LHP_count,
    input  logic [JUMP_STATUS_COUNTER_WIDTH-1:0] RD_GHP_count,
    input  logic [STAT_COUNTER_WIDTH-1:0]        RD_SP_stat_count,
    input  logic [STAT_COUNTER_WIDTH-1:0]        RD_LHP_stat_count,
    input  logic [STAT_COUNTER_WIDTH-1:0]        RD_GHP_stat_count,
    input  logic [2:0]                           RD_SP_trend_count,
    input  logic [2:0]                           RD_LHP_trend_count,
    input  logic [2:0]                           RD_GHP_trend_count,
    input  logic [2:0]                           WR_addr2,
    input  logic                                 WR_SP_en2,
    input  logic                                 WR_LHP_en2,
    input  logic                                 WR_GHP_en2,
    input  logic [STAT_COUNTER_WIDTH-1:0]        WR_SP_stat_count2,
    input  logic [STAT_COUNTER_WIDTH-1:0]        WR_LHP_stat_count2,
    input  logic [STAT_COUNTER_WIDTH-1:0]        WR_GHP_stat_count2,
    input  logic [2:0]                           WR_SP_trend_count2,
    input  logic [2:0]                           WR_LHP_trend_count2,
    input  logic [2:0]                           WR_GHP_trend_count2,
    output logic                                 prediction_en,
    output logic                                 prediction_result,
    output logic [1:0]                           pred_sel,
    output logic                                 SP_prediction_result,
    output logic [JUMP_STATUS_COUNTER_WIDTH-1:0] LHP_count,
    output logic [JUMP_STATUS_COUNTER_WIDTH-1:0] GHP_count,
    output logic [STAT_COUNTER_WIDTH-1:0]        SP_stat_count,
    output logic [STAT_COUNTER_WIDTH-1:0]        LHP_stat_count,
    output logic [STAT_COUNTER_WIDTH-1:0]        GHP_stat_count,
    output logic [2:0]                           SP_trend_count,
    output logic [2:0]                           LHP_trend_count,
    output logic [2:0]                           GHP_trend_count,
    output logic                                 SP_prediction_result_id,
    output logic [JUMP_STATUS_COUNTER_WIDTH-1:0] LHP_count_id,
    output logic [JUMP_STATUS_COUNTER_WIDTH-1:0] GHP_count_id,
    output logic [STAT_COUNTER_WIDTH-1:0]        SP_stat_count_id,
    output logic [STAT_COUNTER_WIDTH-1:0]        LHP_stat_count_id,
    output logic [STAT_COUNTER_WIDTH-1:0]        GHP_stat_count_id,
    output logic [2:0]                           SP_trend_count_id,
    output logic [2:0]                           LHP_trend_count_id,
    output logic [2:0]                           GHP_trend_count_id,
    output logic                                 prediction_result_id,
    output logic [2:0]                           addr_id,
    output logic                                 valid_id,
    output logic                                 SP_prediction_result_ex,
    output logic [JUMP_STATUS_COUNTER_WIDTH-1:0] LHP_count_ex,
    output logic [JUMP_STATUS_COUNTER_WIDTH-1:0] GHP_count_ex,
    output logic [STAT_COUNTER_WIDTH-1:0]        SP_stat_count_ex,
    output logic [STAT_COUNTER_WIDTH-1:0]        LHP_stat_count_ex,
    output logic [STAT_COUNTER_WIDTH-1:0]        GHP_stat_count_ex,
    output logic [2:0]                           SP_trend_count_ex,
    output logic [2:0]                           LHP_trend_count_ex,
    output logic [2:0]                           GHP_trend_count_ex,
    output logic                                 prediction_result_ex,
    output logic [2:0]                           addr_ex,
    output logic                                 valid_ex
);

    typedef enum logic [1:0] {
        SEL_SP  = 2'd0,
        SEL_LHP = 2'd1,
        SEL_GHP = 2'd2
    } sel_t;

    // One pipeline slot worth of prediction metadata.
    typedef struct packed {
        logic                                 sp_dir;
        logic [JUMP_STATUS_COUNTER_WIDTH-1:0] lhp_count;
        logic [JUMP_STATUS_COUNTER_WIDTH-1:0] ghp_count;
        logic [STAT_COUNTER_WIDTH-1:0]        sp_stat;
        logic [STAT_COUNTER_WIDTH-1:0]        lhp_stat;
        logic [STAT_COUNTER_WIDTH-1:0]        ghp_stat;
        logic [2:0]                           sp_trend;
        logic [2:0]                           lhp_trend;
        logic [2:0]                           ghp_trend;
        logic                                 pred;
        logic [2:0]                           addr;
        logic                                 valid;
    } meta_t;

    meta_t if_meta;
    meta_t id_q;
    meta_t ex_q;

    sel_t                          best_sel;
    logic [STAT_COUNTER_WIDTH-1:0] best_stat;
    logic [2:0]                    best_trend;
    logic                          best_dir;

    // a beats b strictly: higher signed stat, or equal stat and higher signed trend
    function automatic logic beats(input logic [STAT_COUNTER_WIDTH-1:0] stat_a,
                                   input logic [2:0]                    trend_a,
                                   input logic [STAT_COUNTER_WIDTH-1:0] stat_b,
                                   input logic [2:0]                    trend_b);
        return ($signed(stat_a) > $signed(stat_b)) ||
               ((stat_a == stat_b) && ($signed(trend_a) > $signed(trend_b)));
    endfunction

    // Bypass write port 2 onto stat/trend counts when it targets the same entry
    always_comb begin
        SP_prediction_result = RD_SP_index;
        LHP_count            = RD_LHP_count;
        GHP_count            = RD_GHP_count;
        SP_stat_count        = RD_SP_stat_count;
        SP_trend_count       = RD_SP_trend_count;
        LHP_stat_count       = RD_LHP_stat_count;
        LHP_trend_count      = RD_LHP_trend_count;
        GHP_stat_count       = RD_GHP_stat_count;
        GHP_trend_count      = RD_GHP_trend_count;
        if (WR_SP_en2 && (WR_addr2 == addr)) begin
            SP_stat_count  = WR_SP_stat_count2;
            SP_trend_count = WR_SP_trend_count2;
        end
        if (WR_LHP_en2 && (WR_addr2 == addr)) begin
            LHP_stat_count  = WR_LHP_stat_count2;
            LHP_trend_count = WR_LHP_trend_count2;
        end
        if (WR_GHP_en2 && (WR_addr2 == addr)) begin
            GHP_stat_count  = WR_GHP_stat_count2;
            GHP_trend_count = WR_GHP_trend_count2;
        end
    end

    // Predictor selection: start from GHP and only switch on a strict win,
    // which yields the GHP > LHP > SP priority on a full tie
    always_comb begin
        best_sel   = SEL_GHP;
        best_stat  = GHP_stat_count;
        best_trend = GHP_trend_count;
        best_dir   = GHP_count[JUMP_STATUS_COUNTER_WIDTH-1];
        if (beats(LHP_stat_count, LHP_trend_count, best_stat, best_trend)) begin
            best_sel   = SEL_LHP;
            best_stat  = LHP_stat_count;
            best_trend = LHP_trend_count;
            best_dir   = LHP_count[JUMP_STATUS_COUNTER_WIDTH-1];
        end
        if (beats(SP_stat_count, SP_trend_count, best_stat, best_trend)) begin
            best_sel   = SEL_SP;
            best_stat  = SP_stat_count;
            best_trend = SP_trend_count;
            best_dir   = SP_prediction_result;
        end
        pred_sel          = branch_valid ? best_sel : SEL_SP;
        prediction_result = branch_valid & best_dir;
    end

    assign prediction_en = branch_valid && !PL_stall && !flush_id;

    assign if_meta = '{
        sp_dir:    SP_prediction_result,
        lhp_count: LHP_count,
        ghp_count: GHP_count,
        sp_stat:   SP_stat_count,
        lhp_stat:  LHP_stat_count,
        ghp_stat:  GHP_stat_count,
        sp_trend:  SP_trend_count,
        lhp_trend: LHP_trend_count,
        ghp_trend: GHP_trend_count,
        pred:      prediction_result,
        addr:      addr,
        valid:     branch_valid && !flush_id
    };

    // IF->ID->EX registers: reset clears, flush_ex kills valids, stall holds
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            id_q <= '0;
            ex_q <= '0;
        end else if (flush_ex) begin
            id_q.valid <= 1'b0;
            ex_q.valid <= 1'b0;
        end else if (!PL_stall) begin
            ex_q <= id_q;
            id_q <= if_meta;
        end
    end

    assign SP_prediction_result_id = id_q.sp_dir;
    assign LHP_count_id            = id_q.lhp_count;
    assign GHP_count_id            = id_q.ghp_count;
    assign SP_stat_count_id        = id_q.sp_stat;
    assign LHP_stat_count_id       = id_q.lhp_stat;
    assign GHP_stat_count_id       = id_q.ghp_stat;
    assign SP_trend_count_id       = id_q.sp_trend;
    assign LHP_trend_count_id      = id_q.lhp_trend;
    assign GHP_trend_count_id      = id_q.ghp_trend;
    assign prediction_result_id    = id_q.pred;
    assign addr_id                 = id_q.addr;
    assign valid_id                = id_q.valid;

    assign SP_prediction_result_ex = ex_q.sp_dir;
    assign LHP_count_ex            = ex_q.lhp_count;
    assign GHP_count_ex            = ex_q.ghp_count;
    assign SP_stat_count_ex        = ex_q.sp_stat;
    assign LHP_stat_count_ex       = ex_q.lhp_stat;
    assign GHP_stat_count_ex       = ex_q.ghp_stat;
    assign SP_trend_count_ex       = ex_q.sp_trend;
    assign LHP_trend_count_ex      = ex_q.lhp_trend;
    assign GHP_trend_count_ex      = ex_q.ghp_trend;
    assign prediction_result_ex    = ex_q.pred;
    assign addr_ex                 = ex_q.addr;
    assign valid_ex                = ex_q.valid;

endmodule

// File: tb/tb_prediction_reader.sv
// Scoreboard bench for prediction_reader: the driver queues expected values
// tagged with the cycle they must appear in; the monitor checks them on negedge.
module tb_prediction_reader;

    localparam int JW = 2;
    localparam int SW = 5;

    logic clk = 1'b0;
    logic rst_n, PL_stall, flush_id, flush_ex, branch_valid;
    logic [2:0] addr, WR_addr2;
    logic RD_SP_index;
    logic [JW-1:0] RD_LHP_count, RD_GHP_count;
    logic [SW-1:0] RD_SP_stat_count, RD_LHP_stat_count, RD_GHP_stat_count;
    logic [2:0] RD_SP_trend_count, RD_LHP_trend_count, RD_GHP_trend_count;
    logic WR_SP_en2, WR_LHP_en2, WR_GHP_en2;
    logic [SW-1:0] WR_SP_stat_count2, WR_LHP_stat_count2, WR_GHP_stat_count2;
    logic [2:0] WR_SP_trend_count2, WR_LHP_trend_count2, WR_GHP_trend_count2;
    logic prediction_en, prediction_result;
    logic [1:0] pred_sel;
    logic SP_prediction_result;
    logic [JW-1:0] LHP_count, GHP_count;
    logic [SW-1:0] SP_stat_count, LHP_stat_count, GHP_stat_count;
    logic [2:0] SP_trend_count, LHP_trend_count, GHP_trend_count;
    logic SP_prediction_result_id, prediction_result_id, valid_id;
    logic [JW-1:0] LHP_count_id, GHP_count_id;
    logic [SW-1:0] SP_stat_count_id, LHP_stat_count_id, GHP_stat_count_id;
    logic [2:0] SP_trend_count_id, LHP_trend_count_id, GHP_trend_count_id, addr_id;
    logic SP_prediction_result_ex, prediction_result_ex, valid_ex;
    logic [JW-1:0] LHP_count_ex, GHP_count_ex;
    logic [SW-1:0] SP_stat_count_ex, LHP_stat_count_ex, GHP_stat_count_ex;
    logic [2:0] SP_trend_count_ex, LHP_trend_count_ex, GHP_trend_count_ex, addr_ex;

    prediction_reader #(
        .JUMP_STATUS_COUNTER_WIDTH(JW),
        .STAT_COUNTER_WIDTH(SW)
    ) dut (
        .clk(clk), .rst_n(rst_n), .PL_stall(PL_stall), .flush_id(flush_id), .flush_ex(flush_ex),
        .branch_valid(branch_valid), .addr(addr), .RD_SP_index(RD_SP_index),
        .RD_LHP_count(RD_LHP_count), .RD_GHP_count(RD_GHP_count),
        .RD_SP_stat_count(RD_SP_stat_count), .RD_LHP_stat_count(RD_LHP_stat_count),
        .RD_GHP_stat_count(RD_GHP_stat_count), .RD_SP_trend_count(RD_SP_trend_count),
        .RD_LHP_trend_count(RD_LHP_trend_count), .RD_GHP_trend_count(RD_GHP_trend_count),
        .WR_addr2(WR_addr2), .WR_SP_en2(WR_SP_en2), .WR_LHP_en2(WR_LHP_en2), .WR_GHP_en2(WR_GHP_en2),
        .WR_SP_stat_count2(WR_SP_stat_count2), .WR_LHP_stat_count2(WR_LHP_stat_count2),
        .WR_GHP_stat_count2(WR_GHP_stat_count2), .WR_SP_trend_count2(WR_SP_trend_count2),
        .WR_LHP_trend_count2(WR_LHP_trend_count2), .WR_GHP_trend_count2(WR_GHP_trend_count2),
        .prediction_en(prediction_en), .prediction_result(prediction_result), .pred_sel(pred_sel),
        .SP_prediction_result(SP_prediction_result), .LHP_count(LHP_count), .GHP_count(GHP_count),
        .SP_stat_count(SP_stat_count), .LHP_stat_count(LHP_stat_count), .GHP_stat_count(GHP_stat_count),
        .SP_trend_count(SP_trend_count), .LHP_trend_count(LHP_trend_count), .GHP_trend_count(GHP_trend_count),
        .SP_prediction_result_id(SP_prediction_result_id), .LHP_count_id(LHP_count_id),
        .GHP_count_id(GHP_count_id), .SP_stat_count_id(SP_stat_count_id),
        .LHP_stat_count_id(LHP_stat_count_id), .GHP_stat_count_id(GHP_stat_count_id),
        .SP_trend_count_id(SP_trend_count_id), .LHP_trend_count_id(LHP_trend_count_id),
        .GHP_trend_count_id(GHP_trend_count_id), .prediction_result_id(prediction_result_id),
        .addr_id(addr_id), .valid_id(valid_id),
        .SP_prediction_result_ex(SP_prediction_result_ex), .LHP_count_ex(LHP_count_ex),
        .GHP_count_ex(GHP_count_ex), .SP_stat_count_ex(SP_stat_count_ex),
        .LHP_stat_count_ex(LHP_stat_count_ex), .GHP_stat_count_ex(GHP_stat_count_ex),
        .SP_trend_count_ex(SP_trend_count_ex), .LHP_trend_count_ex(LHP_trend_count_ex),
        .GHP_trend_count_ex(GHP_trend_count_ex), .prediction_result_ex(prediction_result_ex),
        .addr_ex(addr_ex), .valid_ex(valid_ex)
    );

    always #5 clk = ~clk;

    // Signal selectors for scoreboard entries
    localparam int S_SEL = 0, S_RES = 1, S_EN = 2, S_VID = 3, S_VEX = 4, S_AID = 5, S_AEX = 6,
                   S_GSTAT = 7, S_GSTAT_ID = 8, S_SPTR = 9, S_RES_ID = 10, S_LCNT_EX = 11,
                   S_SPSTAT_EX = 12;

    typedef struct {
        int unsigned tag;
        int          sel;
        logic [7:0]  val;
        string       name;
    } exp_t;

    exp_t sb[$];
    int unsigned cyc = 0;
    int total = 0;
    int bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] actual(input int sel);
        case (sel)
            S_SEL:       return {6'd0, pred_sel};
            S_RES:       return {7'd0, prediction_result};
            S_EN:        return {7'd0, prediction_en};
            S_VID:       return {7'd0, valid_id};
            S_VEX:       return {7'd0, valid_ex};
            S_AID:       return {5'd0, addr_id};
            S_AEX:       return {5'd0, addr_ex};
            S_GSTAT:     return {3'd0, GHP_stat_count};
            S_GSTAT_ID:  return {3'd0, GHP_stat_count_id};
            S_SPTR:      return {5'd0, SP_trend_count};
            S_RES_ID:    return {7'd0, prediction_result_id};
            S_LCNT_EX:   return {6'd0, LHP_count_ex};
            S_SPSTAT_EX: return {3'd0, SP_stat_count_ex};
            default:     return 8'hFF;
        endcase
    endfunction

    // Monitor: compare every entry due in this cycle, away from the clock edge
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].tag == cyc) begin
                total++;
                if (actual(sb[i].sel) !== sb[i].val) begin
                    bad++;
                    $display("FAIL %s (cycle %0d): got %0h expected %0h",
                             sb[i].name, cyc, actual(sb[i].sel), sb[i].val);
                end
                sb.delete(i);
            end
        end
    end

    task automatic chk(input int sel, input logic [7:0] v, input int unsigned off, input string nm);
        exp_t e;
        e.tag = cyc + off;
        e.sel = sel;
        e.val = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        PL_stall = 0; flush_id = 0; flush_ex = 0; branch_valid = 1; addr = 3'd0;
        RD_SP_index = 0; RD_LHP_count = '0; RD_GHP_count = '0;
        RD_SP_stat_count = '0; RD_LHP_stat_count = '0; RD_GHP_stat_count = '0;
        RD_SP_trend_count = '0; RD_LHP_trend_count = '0; RD_GHP_trend_count = '0;
        WR_addr2 = '0; WR_SP_en2 = 0; WR_LHP_en2 = 0; WR_GHP_en2 = 0;
        WR_SP_stat_count2 = '0; WR_LHP_stat_count2 = '0; WR_GHP_stat_count2 = '0;
        WR_SP_trend_count2 = '0; WR_LHP_trend_count2 = '0; WR_GHP_trend_count2 = '0;
    endtask

    task automatic scramble();
        PL_stall = 1'($urandom); flush_id = 1'($urandom); flush_ex = 1'($urandom);
        branch_valid = 1'($urandom); addr = 3'($urandom); RD_SP_index = 1'($urandom);
        RD_LHP_count = JW'($urandom); RD_GHP_count = JW'($urandom);
        RD_SP_stat_count = SW'($urandom); RD_LHP_stat_count = SW'($urandom);
        RD_GHP_stat_count = SW'($urandom); RD_SP_trend_count = 3'($urandom);
        RD_LHP_trend_count = 3'($urandom); RD_GHP_trend_count = 3'($urandom);
        WR_addr2 = 3'($urandom); WR_SP_en2 = 1'($urandom); WR_LHP_en2 = 1'($urandom);
        WR_GHP_en2 = 1'($urandom); WR_SP_stat_count2 = SW'($urandom);
        WR_LHP_stat_count2 = SW'($urandom); WR_GHP_stat_count2 = SW'($urandom);
        WR_SP_trend_count2 = 3'($urandom); WR_LHP_trend_count2 = 3'($urandom);
        WR_GHP_trend_count2 = 3'($urandom);
    endtask

    initial begin
        rst_n = 0;
        scramble();
        // Two reset cycles with random inputs
        for (int i = 0; i < 2; i++) begin
            step();
            scramble();
            chk(S_VID, 8'd0, 0, "rst_valid_id");
            chk(S_VEX, 8'd0, 0, "rst_valid_ex");
            chk(S_AID, 8'd0, 0, "rst_addr_id");
            chk(S_AEX, 8'd0, 0, "rst_addr_ex");
        end
        // Release with a branch at addr 3
        step(); idle(); rst_n = 1; addr = 3'd3;
        chk(S_VID, 8'd1, 1, "rel_valid_id");
        chk(S_AID, 8'd3, 1, "rel_addr_id");
        chk(S_VEX, 8'd1, 2, "rel_valid_ex");
        chk(S_AEX, 8'd3, 2, "rel_addr_ex");

        // SP best (5 vs -2 vs 4), SP direction 0
        step(); idle();
        RD_SP_stat_count = 5'd5; RD_LHP_stat_count = 5'h1E; RD_GHP_stat_count = 5'd4;
        RD_GHP_count = 2'b11;
        chk(S_SEL, 8'd0, 0, "sel_sp");
        chk(S_RES, 8'd0, 0, "res_sp");
        chk(S_EN, 8'd1, 0, "pred_en");

        // LHP ties SP on stat, wins on trend
        step(); idle();
        RD_SP_stat_count = 5'd5; RD_LHP_stat_count = 5'd5; RD_GHP_stat_count = 5'd4;
        RD_SP_trend_count = 3'd1; RD_LHP_trend_count = 3'd2; RD_LHP_count = 2'b10;
        chk(S_SEL, 8'd1, 0, "sel_lhp_trend");
        chk(S_RES, 8'd1, 0, "res_lhp_trend");
        chk(S_LCNT_EX, 8'd2, 2, "lhp_count_ex");

        // Full tie at -16 -> GHP
        step(); idle();
        RD_SP_stat_count = 5'h10; RD_LHP_stat_count = 5'h10; RD_GHP_stat_count = 5'h10;
        RD_SP_index = 1; RD_GHP_count = 2'b10;
        chk(S_SEL, 8'd2, 0, "sel_tie_ghp");
        chk(S_RES, 8'd1, 0, "res_tie_ghp");
        chk(S_RES_ID, 8'd1, 1, "res_id");

        // No branch: result and select forced to 0
        step(); idle(); branch_valid = 0;
        RD_GHP_stat_count = 5'd9; RD_GHP_count = 2'b11;
        chk(S_SEL, 8'd0, 0, "nobr_sel");
        chk(S_RES, 8'd0, 0, "nobr_res");
        chk(S_EN, 8'd0, 0, "nobr_en");
        chk(S_VID, 8'd0, 1, "nobr_valid_id");

        // Bypass hit on GHP stat
        step(); idle(); addr = 3'd2;
        RD_GHP_stat_count = 5'h1D; RD_GHP_count = 2'b11;
        WR_GHP_en2 = 1; WR_addr2 = 3'd2; WR_GHP_stat_count2 = 5'd7;
        chk(S_SEL, 8'd2, 0, "byp_hit_sel");
        chk(S_RES, 8'd1, 0, "byp_hit_res");
        chk(S_GSTAT, 8'd7, 0, "byp_hit_stat");
        chk(S_GSTAT_ID, 8'd7, 1, "byp_hit_stat_id");

        // Bypass miss: address differs, LHP beats SP on tie
        step(); idle(); addr = 3'd2;
        RD_GHP_stat_count = 5'h1D; RD_GHP_count = 2'b11;
        WR_GHP_en2 = 1; WR_addr2 = 3'd3; WR_GHP_stat_count2 = 5'd7;
        chk(S_SEL, 8'd1, 0, "byp_miss_sel");
        chk(S_GSTAT, 8'h1D, 0, "byp_miss_stat");

        // Bypass of SP trend breaks the stat tie
        step(); idle(); addr = 3'd4;
        WR_SP_en2 = 1; WR_addr2 = 3'd4; WR_SP_trend_count2 = 3'd3;
        chk(S_SEL, 8'd0, 0, "byp_trend_sel");
        chk(S_SPTR, 8'd3, 0, "byp_trend_val");

        // Signed edge: +15 must beat -16
        step(); idle();
        RD_SP_stat_count = 5'h0F; RD_LHP_stat_count = 5'h10; RD_LHP_count = 2'b11;
        chk(S_SEL, 8'd0, 0, "sign_sel");
        chk(S_RES, 8'd0, 0, "sign_res");
        chk(S_SPSTAT_EX, 8'h0F, 2, "sign_stat_ex");

        // Stall: A=1, B=6, then hold for 3 cycles
        step(); idle(); addr = 3'd1;
        step(); idle(); addr = 3'd6;
        for (int i = 0; i < 3; i++) begin
            step(); idle(); addr = 3'd7; PL_stall = 1;
            chk(S_AID, 8'd6, 0, "stall_addr_id");
            chk(S_AEX, 8'd1, 0, "stall_addr_ex");
            chk(S_VID, 8'd1, 0, "stall_valid_id");
            chk(S_EN, 8'd0, 0, "stall_en");
        end
        step(); idle(); addr = 3'd4;
        chk(S_AID, 8'd6, 0, "stall_last_id");
        chk(S_AEX, 8'd1, 0, "stall_last_ex");
        chk(S_AEX, 8'd6, 1, "release_addr_ex");
        chk(S_AID, 8'd4, 1, "release_addr_id");

        // flush_id: ID loads data but not valid; EX takes old ID
        step(); idle(); addr = 3'd5; flush_id = 1;
        chk(S_EN, 8'd0, 0, "flid_en");
        chk(S_VID, 8'd0, 1, "flid_valid_id");
        chk(S_AID, 8'd5, 1, "flid_addr_id");
        chk(S_AEX, 8'd4, 1, "flid_addr_ex");
        chk(S_VEX, 8'd1, 1, "flid_valid_ex");

        step(); idle(); addr = 3'd3;
        chk(S_VID, 8'd1, 1, "post_flid_valid_id");
        chk(S_VEX, 8'd0, 1, "post_flid_valid_ex");

        // flush_ex during stall: both valids drop, data holds
        step(); idle(); addr = 3'd2; PL_stall = 1; flush_ex = 1;
        chk(S_VID, 8'd0, 1, "flex_valid_id");
        chk(S_VEX, 8'd0, 1, "flex_valid_ex");
        chk(S_AID, 8'd3, 1, "flex_addr_id");
        chk(S_AEX, 8'd5, 1, "flex_addr_ex");

        // Reset during stall and flush wins
        step(); idle(); addr = 3'd6;
        step(); idle(); addr = 3'd1; PL_stall = 1; flush_ex = 1; rst_n = 0;
        chk(S_AID, 8'd0, 1, "rst_stall_addr_id");
        chk(S_AEX, 8'd0, 1, "rst_stall_addr_ex");
        chk(S_VID, 8'd0, 1, "rst_stall_valid_id");

        step(); idle(); rst_n = 1; branch_valid = 0;
        for (int i = 0; i < 3; i++) step();

        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
